// File: rtl/dram_pkg.sv
// Shared definitions for the multi-port DRAM arbiter: FSM encoding, DRAM bus
// widths and offset helpers for the flattened per-port request buses.
package dram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

  localparam int DRAM_DW  = 32;
  localparam int DRAM_BEW = 4;

  // Low bit of port `port` in a bus made of `width`-bit fields per port.
  function automatic int slice_lo(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational NPORT-wide picker: round-robin from i_ptr when RR != 0,
// otherwise fixed priority with port 0 highest.
module rr_pick #(
  parameter int NPORT = 2,
  parameter int PW    = 1,
  parameter int RR    = 1
) (
  input  logic [NPORT-1:0] i_req,
  input  logic [PW-1:0]    i_ptr,
  output logic [NPORT-1:0] o_gnt,
  output logic [PW-1:0]    o_idx
);

  logic          w_found;
  logic [PW-1:0] w_sel;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_sel   = '0;
    for (int k = 0; k < NPORT; k++) begin
      // Candidate order starts at the pointer and wraps at NPORT, not at 2**PW.
      if (RR != 0) w_sel = PW'((int'(i_ptr) + k) % NPORT);
      else         w_sel = PW'(k);
      if (!w_found && i_req[w_sel]) begin
        w_found      = 1'b1;
        o_gnt[w_sel] = 1'b1;
        o_idx        = w_sel;
      end
    end
  end

endmodule

// File: rtl/dram_port_arbiter.sv
// N-port DRAM arbiter: one buffered request per port, serialised onto the
// single DRAM port, with read data / write acknowledge routed back to the owner.
module dram_port_arbiter
  import dram_pkg::*;
#(
  parameter int NPORT     = 2,
  parameter int MEM_SCALE = 27,
  parameter int RR        = 1
) (
  input  logic                        clk,
  input  logic                        rst_x,
  input  logic [NPORT-1:0]            p_oe,
  input  logic [NPORT*MEM_SCALE-1:0]  p_addr,
  input  logic [NPORT*DRAM_DW-1:0]    p_wdata,
  input  logic [NPORT*DRAM_BEW-1:0]   p_we,
  output logic [DRAM_DW-1:0]          p_rdata,
  output logic [NPORT-1:0]            p_valid,
  output logic [NPORT-1:0]            p_written,
  output logic [NPORT-1:0]            p_busy,
  output logic                        overflow,
  output logic                        dram_oe,
  output logic [MEM_SCALE-1:0]        dram_addr,
  output logic [DRAM_DW-1:0]          dram_wdata,
  output logic [DRAM_BEW-1:0]         dram_we,
  input  logic [DRAM_DW-1:0]          dram_rdata,
  input  logic                        dram_valid,
  input  logic                        dram_written
);

  localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;

  arb_state_e r_state, w_state_nxt;

  logic [NPORT-1:0]     r_pend, w_acc, w_clr, w_gnt, r_gnt_oh;
  logic [PW-1:0]        w_idx, r_g, r_ptr;
  logic                 r_is_wr, w_grant, w_done, w_ovf;

  logic [MEM_SCALE-1:0] r_addr  [NPORT];
  logic [DRAM_DW-1:0]   r_wdata [NPORT];
  logic [DRAM_BEW-1:0]  r_we    [NPORT];

  logic [DRAM_DW-1:0]   r_p_rdata;
  logic [NPORT-1:0]     r_p_valid, r_p_written;
  logic                 r_ovf, r_dram_oe;
  logic [MEM_SCALE-1:0] r_dram_addr;
  logic [DRAM_DW-1:0]   r_dram_wdata;
  logic [DRAM_BEW-1:0]  r_dram_we;

  rr_pick #(
    .NPORT (NPORT),
    .PW    (PW),
    .RR    (RR)
  ) u_pick (
    .i_req (r_pend),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx)
  );

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|r_pend) begin
          w_grant     = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        // Only the strobe matching the transaction type completes it.
        if (r_is_wr ? dram_written : dram_valid) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // A completion frees its port in the same cycle, so a re-request there is accepted.
  always_comb begin
    w_clr = w_done ? r_gnt_oh : '0;
    w_acc = p_oe & (~r_pend | w_clr);
    w_ovf = |(p_oe & r_pend & ~w_clr);
  end

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      for (int i = 0; i < NPORT; i++) begin
        r_addr[i]  <= '0;
        r_wdata[i] <= '0;
        r_we[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < NPORT; i++) begin
        if (w_acc[i]) begin
          r_addr[i]  <= p_addr[slice_lo(i, MEM_SCALE) +: MEM_SCALE];
          r_wdata[i] <= p_wdata[slice_lo(i, DRAM_DW) +: DRAM_DW];
          r_we[i]    <= p_we[slice_lo(i, DRAM_BEW) +: DRAM_BEW];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      r_pend       <= '0;
      r_ovf        <= 1'b0;
      r_ptr        <= '0;
      r_g          <= '0;
      r_gnt_oh     <= '0;
      r_is_wr      <= 1'b0;
      r_dram_oe    <= 1'b0;
      r_dram_addr  <= '0;
      r_dram_wdata <= '0;
      r_dram_we    <= '0;
      r_p_valid    <= '0;
      r_p_written  <= '0;
      r_p_rdata    <= '0;
    end else begin
      r_pend      <= (r_pend & ~w_clr) | w_acc;
      r_ovf       <= r_ovf | w_ovf;
      r_dram_oe   <= w_grant;
      r_p_valid   <= (w_done && !r_is_wr) ? r_gnt_oh : '0;
      r_p_written <= (w_done &&  r_is_wr) ? r_gnt_oh : '0;
      if (w_done && !r_is_wr) r_p_rdata <= dram_rdata;
      if (w_grant) begin
        r_g          <= w_idx;
        r_gnt_oh     <= w_gnt;
        r_is_wr      <= |r_we[w_idx];
        r_dram_addr  <= r_addr[w_idx];
        r_dram_wdata <= r_wdata[w_idx];
        r_dram_we    <= r_we[w_idx];
      end
      if (r_state == ST_ISSUE) r_ptr <= (r_g == PW'(NPORT - 1)) ? '0 : r_g + 1'b1;
    end
  end

  assign p_busy     = r_pend;
  assign overflow   = r_ovf;
  assign dram_oe    = r_dram_oe;
  assign dram_addr  = r_dram_addr;
  assign dram_wdata = r_dram_wdata;
  assign dram_we    = r_dram_we;
  assign p_valid    = r_p_valid;
  assign p_written  = r_p_written;
  assign p_rdata    = r_p_rdata;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Scoreboard bench: a round-robin instance (A) and a fixed-priority instance (B),
// both 3 ports; expected issues/responses are queued and checked by monitors.
module tb_dram_port_arbiter;
  localparam int NP = 3;
  localparam int AW = 27;

  typedef struct {
    logic [AW-1:0] addr;
    logic [3:0]    we;
    logic [31:0]   wdata;
    int            cyc;
  } iss_t;

  typedef struct {
    logic [NP-1:0] port;
    logic          wr;
    logic [31:0]   rdata;
  } rsp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  iss_t q_iss_a[$];
  rsp_t q_rsp_a[$];
  iss_t q_iss_b[$];
  rsp_t q_rsp_b[$];
  logic [31:0] last_rd;

  // instance A (round-robin)
  logic             rst_a;
  logic [NP-1:0]    a_p_oe;
  logic [NP*AW-1:0] a_p_addr;
  logic [NP*32-1:0] a_p_wdata;
  logic [NP*4-1:0]  a_p_we;
  logic [31:0]      a_p_rdata;
  logic [NP-1:0]    a_p_valid, a_p_written, a_p_busy;
  logic             a_ovf, a_dram_oe;
  logic [AW-1:0]    a_dram_addr;
  logic [31:0]      a_dram_wdata;
  logic [3:0]       a_dram_we;
  logic [31:0]      a_dram_rdata;
  logic             a_dram_valid, a_dram_written;
  logic             auto_a, auto_valid, auto_written, man_valid, man_written;
  logic [31:0]      auto_rdata, man_rdata;

  assign a_dram_valid   = auto_valid | man_valid;
  assign a_dram_written = auto_written | man_written;
  assign a_dram_rdata   = auto_valid ? auto_rdata : man_rdata;

  // instance B (fixed priority)
  logic             rst_b;
  logic [NP-1:0]    b_p_oe;
  logic [NP*AW-1:0] b_p_addr;
  logic [NP*32-1:0] b_p_wdata;
  logic [NP*4-1:0]  b_p_we;
  logic [31:0]      b_p_rdata;
  logic [NP-1:0]    b_p_valid, b_p_written, b_p_busy;
  logic             b_ovf, b_dram_oe;
  logic [AW-1:0]    b_dram_addr;
  logic [31:0]      b_dram_wdata;
  logic [3:0]       b_dram_we;
  logic [31:0]      b_dram_rdata;
  logic             b_dram_valid;
  logic             b_dram_written;

  dram_port_arbiter #(.NPORT(NP), .MEM_SCALE(AW), .RR(1)) u_dut_a (
    .clk(clk), .rst_x(rst_a),
    .p_oe(a_p_oe), .p_addr(a_p_addr), .p_wdata(a_p_wdata), .p_we(a_p_we),
    .p_rdata(a_p_rdata), .p_valid(a_p_valid), .p_written(a_p_written), .p_busy(a_p_busy),
    .overflow(a_ovf), .dram_oe(a_dram_oe), .dram_addr(a_dram_addr),
    .dram_wdata(a_dram_wdata), .dram_we(a_dram_we), .dram_rdata(a_dram_rdata),
    .dram_valid(a_dram_valid), .dram_written(a_dram_written)
  );

  dram_port_arbiter #(.NPORT(NP), .MEM_SCALE(AW), .RR(0)) u_dut_b (
    .clk(clk), .rst_x(rst_b),
    .p_oe(b_p_oe), .p_addr(b_p_addr), .p_wdata(b_p_wdata), .p_we(b_p_we),
    .p_rdata(b_p_rdata), .p_valid(b_p_valid), .p_written(b_p_written), .p_busy(b_p_busy),
    .overflow(b_ovf), .dram_oe(b_dram_oe), .dram_addr(b_dram_addr),
    .dram_wdata(b_dram_wdata), .dram_we(b_dram_we), .dram_rdata(b_dram_rdata),
    .dram_valid(b_dram_valid), .dram_written(b_dram_written)
  );

  function automatic logic [31:0] rdata_of(input logic [AW-1:0] a);
    if (a == 27'h100) return 32'hDEADBEEF;
    return {5'b0, a} ^ 32'h5A5A_5A5A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_iss_a(input logic [AW-1:0] ad, input logic [3:0] we, input logic [31:0] wd, input int c);
    iss_t e;
    e.addr = ad; e.we = we; e.wdata = wd; e.cyc = c;
    q_iss_a.push_back(e);
  endtask

  task automatic exp_rsp_a(input logic [NP-1:0] port, input logic wr, input logic [31:0] rd);
    rsp_t e;
    e.port = port; e.wr = wr; e.rdata = rd;
    q_rsp_a.push_back(e);
    if (!wr) last_rd = rd;
  endtask

  task automatic a_set(input int p, input logic [AW-1:0] ad, input logic [31:0] wd, input logic [3:0] we);
    a_p_oe[p]              = 1'b1;
    a_p_addr[p*AW +: AW]   = ad;
    a_p_wdata[p*32 +: 32]  = wd;
    a_p_we[p*4 +: 4]       = we;
  endtask

  task automatic b_set(input int p, input logic [AW-1:0] ad);
    b_p_oe[p]              = 1'b1;
    b_p_addr[p*AW +: AW]   = ad;
    b_p_wdata[p*32 +: 32]  = '0;
    b_p_we[p*4 +: 4]       = '0;
  endtask

  task automatic wait_oe_a();
    int n = 0;
    while (!a_dram_oe && n < 40) begin tick(); n++; end
    check("a_oe_seen", 32'(a_dram_oe), 32'd1);
  endtask

  task automatic wait_oe_b();
    int n = 0;
    while (!b_dram_oe && n < 40) begin tick(); n++; end
    check("b_oe_seen", 32'(b_dram_oe), 32'd1);
  endtask

  task automatic wait_idle_a();
    int n = 0;
    while ((a_p_busy != 0 || q_iss_a.size() != 0 || q_rsp_a.size() != 0) && n < 300) begin
      tick(); n++;
    end
    check("a_drained", 32'(a_p_busy == 0 && q_iss_a.size() == 0 && q_rsp_a.size() == 0), 32'd1);
  endtask

  task automatic wait_idle_b();
    int n = 0;
    while ((b_p_busy != 0 || q_iss_b.size() != 0 || q_rsp_b.size() != 0) && n < 300) begin
      tick(); n++;
    end
    check("b_drained", 32'(b_p_busy == 0 && q_iss_b.size() == 0 && q_rsp_b.size() == 0), 32'd1);
  endtask

  task automatic check_zero_a(input string tag);
    check({tag, "_dram_oe"},    32'(a_dram_oe), 32'd0);
    check({tag, "_dram_addr"},  32'(a_dram_addr), 32'd0);
    check({tag, "_dram_we"},    32'(a_dram_we), 32'd0);
    check({tag, "_dram_wdata"}, a_dram_wdata, 32'd0);
    check({tag, "_p_strobes"},  32'(a_p_valid | a_p_written), 32'd0);
    check({tag, "_p_busy"},     32'(a_p_busy), 32'd0);
    check({tag, "_overflow"},   32'(a_ovf), 32'd0);
    check({tag, "_p_rdata"},    a_p_rdata, 32'd0);
  endtask

  // automatic DRAM model for A: respond four cycles after the issue strobe
  initial begin
    logic [AW-1:0] ad;
    logic          wr;
    auto_valid = 1'b0; auto_written = 1'b0; auto_rdata = '0;
    forever begin
      @(negedge clk);
      if (auto_a && rst_a && a_dram_oe) begin
        ad = a_dram_addr;
        wr = |a_dram_we;
        repeat (4) @(posedge clk);
        #1;
        if (wr) auto_written = 1'b1;
        else begin
          auto_valid = 1'b1;
          auto_rdata = rdata_of(ad);
        end
        @(posedge clk);
        #1;
        auto_valid   = 1'b0;
        auto_written = 1'b0;
      end
    end
  end

  // monitor A
  initial begin
    iss_t ei;
    rsp_t er;
    forever begin
      @(negedge clk);
      if (rst_a) begin
        if (a_dram_oe) begin
          check("a_issue_expected", 32'(q_iss_a.size() != 0), 32'd1);
          if (q_iss_a.size() != 0) begin
            ei = q_iss_a.pop_front();
            check("a_issue_addr", 32'(a_dram_addr), 32'(ei.addr));
            check("a_issue_we", 32'(a_dram_we), 32'(ei.we));
            check("a_issue_wdata", a_dram_wdata, ei.wdata);
            if (ei.cyc >= 0) check("a_issue_cycle", 32'(cyc), 32'(ei.cyc));
          end
        end
        if (|a_p_valid || |a_p_written) begin
          check("a_resp_expected", 32'(q_rsp_a.size() != 0), 32'd1);
          if (q_rsp_a.size() != 0) begin
            er = q_rsp_a.pop_front();
            if (er.wr) begin
              check("a_p_written", 32'(a_p_written), 32'(er.port));
              check("a_p_valid_on_write", 32'(a_p_valid), 32'd0);
            end else begin
              check("a_p_valid", 32'(a_p_valid), 32'(er.port));
              check("a_p_written_on_read", 32'(a_p_written), 32'd0);
              check("a_p_rdata", a_p_rdata, er.rdata);
            end
          end
        end
      end
    end
  end

  // monitor B
  initial begin
    iss_t ei;
    rsp_t er;
    forever begin
      @(negedge clk);
      if (rst_b) begin
        if (b_dram_oe) begin
          check("b_issue_expected", 32'(q_iss_b.size() != 0), 32'd1);
          if (q_iss_b.size() != 0) begin
            ei = q_iss_b.pop_front();
            check("b_issue_addr", 32'(b_dram_addr), 32'(ei.addr));
          end
        end
        if (|b_p_valid || |b_p_written) begin
          check("b_resp_expected", 32'(q_rsp_b.size() != 0), 32'd1);
          if (q_rsp_b.size() != 0) begin
            er = q_rsp_b.pop_front();
            check("b_p_valid", 32'(b_p_valid), 32'(er.port));
            check("b_p_written", 32'(b_p_written), 32'd0);
            check("b_p_rdata", b_p_rdata, er.rdata);
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    iss_t bi;
    rsp_t br;
    logic [AW-1:0] b_addrs [6];
    logic [NP-1:0] b_ports [6];

    rst_a = 1'b0; rst_b = 1'b0; auto_a = 1'b1;
    man_valid = 1'b0; man_written = 1'b0; man_rdata = '0;
    a_p_oe = '0; a_p_addr = '0; a_p_wdata = '0; a_p_we = '0;
    b_p_oe = '0; b_p_addr = '0; b_p_wdata = '0; b_p_we = '0;
    b_dram_valid = 1'b0; b_dram_written = 1'b0; b_dram_rdata = '0;
    last_rd = '0;

    repeat (2) tick();
    check_zero_a("rst_init");
    rst_a = 1'b1; rst_b = 1'b1;
    tick();

    // single read from port 1
    a_set(1, 27'h100, 32'h0, 4'h0);
    exp_iss_a(27'h100, 4'h0, 32'h0, cyc + 2);
    exp_rsp_a(3'b010, 1'b0, 32'hDEADBEEF);
    tick(); a_p_oe = '0;
    wait_idle_a();
    check("single_busy_clear", 32'(a_p_busy), 32'd0);
    repeat (3) tick();
    check("single_rdata_hold", a_p_rdata, 32'hDEADBEEF);

    // restart with pointer at 0, then four rounds of all-port requests
    rst_a = 1'b0; tick(); tick(); rst_a = 1'b1; tick();
    for (int r = 0; r < 4; r++) begin
      for (int p = 0; p < NP; p++) begin
        a_set(p, AW'(32'h1000 * (p + 1) + 32'(r * 4)), 32'h0, 4'h0);
        exp_iss_a(AW'(32'h1000 * (p + 1) + 32'(r * 4)), 4'h0, 32'h0, -1);
        exp_rsp_a(NP'(1 << p), 1'b0, rdata_of(AW'(32'h1000 * (p + 1) + 32'(r * 4))));
      end
      tick(); a_p_oe = '0;
      wait_idle_a();
    end

    // port 1 alone moves the pointer to 2; then ports 0 and 2 together: 2 wins first
    a_set(1, 27'h2100, 32'h0, 4'h0);
    exp_iss_a(27'h2100, 4'h0, 32'h0, -1);
    exp_rsp_a(3'b010, 1'b0, rdata_of(27'h2100));
    tick(); a_p_oe = '0;
    wait_idle_a();
    a_set(0, 27'h2000, 32'hAAAA5555, 4'hF);
    a_set(2, 27'h2200, 32'h0, 4'h0);
    exp_iss_a(27'h2200, 4'h0, 32'h0, -1);
    exp_iss_a(27'h2000, 4'hF, 32'hAAAA5555, -1);
    exp_rsp_a(3'b100, 1'b0, rdata_of(27'h2200));
    exp_rsp_a(3'b001, 1'b1, 32'h0);
    tick(); a_p_oe = '0;
    wait_idle_a();

    // write ack routing with a stray dram_valid first
    auto_a = 1'b0;
    a_set(2, 27'h200, 32'h12345678, 4'b0011);
    exp_iss_a(27'h200, 4'b0011, 32'h12345678, cyc + 2);
    exp_rsp_a(3'b100, 1'b1, 32'h0);
    tick(); a_p_oe = '0;
    wait_oe_a();
    tick();
    man_valid = 1'b1; man_rdata = 32'hBAD0BAD0;
    tick(); man_valid = 1'b0;
    tick();
    check("wr_we_held", 32'(a_dram_we), 32'h3);
    check("wr_wdata_held", a_dram_wdata, 32'h12345678);
    check("wr_addr_held", 32'(a_dram_addr), 32'h200);
    check("wr_busy", 32'(a_p_busy), 32'h4);
    man_written = 1'b1;
    tick(); man_written = 1'b0;
    tick(); tick();
    check("wr_rdata_unchanged", a_p_rdata, last_rd);
    wait_idle_a();

    // re-request in the same cycle as completion
    check("ovf_initially_clear", 32'(a_ovf), 32'd0);
    a_set(0, 27'h300, 32'h0, 4'h0);
    exp_iss_a(27'h300, 4'h0, 32'h0, cyc + 2);
    exp_rsp_a(3'b001, 1'b0, 32'h11112222);
    tick(); a_p_oe = '0;
    wait_oe_a();
    tick();
    man_valid = 1'b1; man_rdata = 32'h11112222;
    a_set(0, 27'h301, 32'h0, 4'h0);
    exp_iss_a(27'h301, 4'h0, 32'h0, cyc + 2);
    exp_rsp_a(3'b001, 1'b0, 32'h33334444);
    tick(); man_valid = 1'b0; a_p_oe = '0;
    wait_oe_a();
    tick();
    man_valid = 1'b1; man_rdata = 32'h33334444;
    tick(); man_valid = 1'b0;
    wait_idle_a();
    check("ovf_same_cycle_clear", 32'(a_ovf), 32'd0);

    // request to a busy port is dropped and flags overflow
    auto_a = 1'b1;
    a_set(0, 27'h400, 32'h0, 4'h0);
    exp_iss_a(27'h400, 4'h0, 32'h0, cyc + 2);
    exp_rsp_a(3'b001, 1'b0, rdata_of(27'h400));
    tick();
    a_set(0, 27'h404, 32'h0, 4'h0);
    tick(); a_p_oe = '0;
    wait_idle_a();
    repeat (8) tick();
    check("ovf_set", 32'(a_ovf), 32'd1);

    // reset during WAIT, then a late DRAM response
    auto_a = 1'b0;
    a_set(1, 27'h500, 32'h0, 4'h0);
    exp_iss_a(27'h500, 4'h0, 32'h0, cyc + 2);
    tick(); a_p_oe = '0;
    wait_oe_a();
    tick();
    rst_a = 1'b0;
    #1;
    check_zero_a("rst_mid");
    tick();
    rst_a = 1'b1;
    tick();
    man_valid = 1'b1; man_rdata = 32'hFACEFACE;
    tick(); man_valid = 1'b0;
    tick(); tick();
    check("late_busy", 32'(a_p_busy), 32'd0);
    check("late_rdata", a_p_rdata, 32'd0);
    check("late_ovf", 32'(a_ovf), 32'd0);
    auto_a = 1'b1;
    a_set(2, 27'h600, 32'h0, 4'h0);
    a_set(1, 27'h610, 32'h0, 4'h0);
    exp_iss_a(27'h610, 4'h0, 32'h0, cyc + 2);
    exp_iss_a(27'h600, 4'h0, 32'h0, -1);
    exp_rsp_a(3'b010, 1'b0, rdata_of(27'h610));
    exp_rsp_a(3'b100, 1'b0, rdata_of(27'h600));
    tick(); a_p_oe = '0;
    wait_idle_a();

    // fixed priority: port 0 re-requests on each completion and keeps winning
    b_addrs = '{27'h700, 27'h701, 27'h702, 27'h703, 27'h710, 27'h720};
    b_ports = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b100};
    for (int k = 0; k < 6; k++) begin
      bi.addr = b_addrs[k]; bi.we = '0; bi.wdata = '0; bi.cyc = -1;
      q_iss_b.push_back(bi);
      br.port = b_ports[k]; br.wr = 1'b0; br.rdata = 32'hB000_0000 + 32'(k);
      q_rsp_b.push_back(br);
    end
    b_set(0, 27'h700); b_set(1, 27'h710); b_set(2, 27'h720);
    tick(); b_p_oe = '0;
    for (int k = 0; k < 6; k++) begin
      wait_oe_b();
      tick();
      b_dram_valid = 1'b1;
      b_dram_rdata = 32'hB000_0000 + 32'(k);
      if (k < 3) b_set(0, AW'(32'h701 + 32'(k)));
      tick();
      b_dram_valid = 1'b0;
      b_p_oe = '0;
    end
    wait_idle_b();
    check("b_ovf_clear", 32'(b_ovf), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
